// File: rtl/mult_acc_pkg.sv
// Shared types, default widths and parameter legality check for the
// product accumulator slice.
package mult_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DEF_PROD_W = 8;
  localparam int DEF_ACC_W  = 16;

  // Term counter must hold N_TERMS without wrapping; accumulator needs at
  // least one bit of headroom over a single product.
  function automatic bit params_legal(input int prod_w, input int acc_w,
                                      input int n_terms, input int cnt_w);
    bit ok;
    ok = (prod_w >= 1) && (acc_w >= prod_w + 1) &&
         (n_terms >= 1) && (n_terms <= 255) &&
         (cnt_w >= 1) && (cnt_w <= 30);
    if (ok) ok = ((1 << cnt_w) > n_terms);
    return ok;
  endfunction

endpackage

// File: rtl/acc_add_ovf.sv
// Running-sum adder: ACC_W accumulator plus zero-extended PROD_W product,
// with the carry-out exposed for overflow tracking.
module acc_add_ovf
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};

endmodule

// File: rtl/mult_prod_accumulator.sv
// Accumulates groups of multiplier products into one wide sum per group,
// with valid/ready handshakes on both the product and result sides.
module mult_prod_accumulator
  import mult_acc_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int N_TERMS = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_valid_i,
  input  logic              prod_last_i,
  output logic              prod_ready_o,
  input  logic              clear_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              acc_ovf_o,
  output logic [CNT_W-1:0]  acc_cnt_o,
  output logic              acc_valid_o,
  input  logic              acc_ready_i
);

  if (!params_legal(PROD_W, ACC_W, N_TERMS, CNT_W)) begin : g_param_check
    $error("mult_prod_accumulator: illegal PROD_W/ACC_W/N_TERMS/CNT_W");
  end

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   res_sum_q, res_sum_d;
  logic               res_ovf_q, res_ovf_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;
  logic [CNT_W-1:0]   cnt_inc;
  logic               in_hs;
  logic               out_hs;
  logic               closes;

  // The running sum is always zero while a result is held, so the same
  // adder serves both a continuing group and a group started from HOLD.
  acc_add_ovf #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .a     (sum_q),
    .b     (prod_i),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign acc_valid_o = (state_q == HOLD);
  assign acc_o       = res_sum_q;
  assign acc_ovf_o   = res_ovf_q;
  assign acc_cnt_o   = res_cnt_q;

  always_comb begin
    prod_ready_o = 1'b1;
    if (rst || clear_i)       prod_ready_o = 1'b0;
    else if (state_q == HOLD) prod_ready_o = acc_ready_i;
  end

  assign in_hs   = prod_valid_i & prod_ready_o;
  assign out_hs  = acc_valid_o & acc_ready_i;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign closes  = (cnt_inc == CNT_W'(N_TERMS)) | prod_last_i;

  // NOTE: every signal gets its hold value first so no path through this
  // block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_sum_d = res_sum_q;
    res_ovf_d = res_ovf_q;
    res_cnt_d = res_cnt_q;

    if (in_hs) begin
      // In HOLD an accepted product implies the result left the same cycle.
      if (closes) begin
        res_sum_d = add_sum;
        res_ovf_d = ovf_q | add_carry;
        res_cnt_d = cnt_inc;
        sum_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        state_d   = HOLD;
      end else begin
        sum_d   = add_sum;
        cnt_d   = cnt_inc;
        ovf_d   = ovf_q | add_carry;
        state_d = ACCUM;
      end
    end else begin
      if (clear_i) begin
        sum_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      if (out_hs) state_d = ACCUM;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order. The result
  // registers are reset too because they drive visible outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      sum_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_sum_q <= '0;
      res_ovf_q <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_sum_q <= res_sum_d;
      res_ovf_q <= res_ovf_d;
      res_cnt_q <= res_cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_prod_accumulator.sv
// Scoreboard bench: three accumulator configurations (default, ACC_W=9,
// N_TERMS=1) driven by directed and random stimulus against a group model.
module tb_mult_prod_accumulator;

  typedef struct packed {
    logic [15:0] sum;
    logic        ovf;
    logic [7:0]  cnt;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit done [3];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AW = (g == 1) ? 9 : 16;
    localparam int NT = (g == 2) ? 1 : 4;

    logic          rst = 1'b1;
    logic [7:0]    prod = '0;
    logic          prod_valid = 1'b0;
    logic          prod_last = 1'b0;
    logic          prod_ready;
    logic          clear = 1'b0;
    logic [AW-1:0] acc;
    logic          acc_ovf;
    logic [7:0]    acc_cnt;
    logic          acc_valid;
    logic          acc_ready = 1'b0;

    mult_prod_accumulator #(
      .PROD_W  (8),
      .ACC_W   (AW),
      .N_TERMS (NT),
      .CNT_W   (8)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .prod_i       (prod),
      .prod_valid_i (prod_valid),
      .prod_last_i  (prod_last),
      .prod_ready_o (prod_ready),
      .clear_i      (clear),
      .acc_o        (acc),
      .acc_ovf_o    (acc_ovf),
      .acc_cnt_o    (acc_cnt),
      .acc_valid_o  (acc_valid),
      .acc_ready_i  (acc_ready)
    );

    // Group model: plain integer sum of the accepted products.
    res_t exp_q[$];
    int   msum    = 0;
    int   mcnt    = 0;
    bit   pending = 1'b0;
    res_t cur     = '0;

    task automatic step(input logic v, input logic [7:0] p, input logic l,
                        input logic c, input logic ar, input logic r);
      logic exp_rdy;
      res_t nr;
      @(posedge clk);
      #1;
      prod_valid = v; prod = p; prod_last = l;
      clear = c; acc_ready = ar; rst = r;
      @(negedge clk);
      exp_rdy = !r && !c && (!pending || ar);
      check($sformatf("g%0d prod_ready", g), 32'(prod_ready), 32'(exp_rdy));
      check($sformatf("g%0d acc_valid", g), 32'(acc_valid), 32'(pending));
      if (pending) begin
        check($sformatf("g%0d held acc", g), 32'(acc), 32'(cur.sum));
        check($sformatf("g%0d held ovf", g), 32'(acc_ovf), 32'(cur.ovf));
        check($sformatf("g%0d held cnt", g), 32'(acc_cnt), 32'(cur.cnt));
      end
      if (r) begin
        msum = 0; mcnt = 0; pending = 1'b0;
        exp_q.delete();
      end else begin
        if (pending && ar) pending = 1'b0;
        if (c) begin
          msum = 0; mcnt = 0;
        end else if (v && exp_rdy) begin
          msum += int'(p);
          mcnt++;
          if (mcnt == NT || l) begin
            nr.sum = 16'(msum % (1 << AW));
            nr.ovf = (msum >= (1 << AW));
            nr.cnt = 8'(mcnt);
            exp_q.push_back(nr);
            cur = nr;
            pending = 1'b1;
            msum = 0; mcnt = 0;
          end
        end
      end
    endtask

    always @(negedge clk) begin
      res_t r;
      if (!rst && acc_valid && acc_ready) begin
        check($sformatf("g%0d result expected", g), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          check($sformatf("g%0d acc_o", g), 32'(acc), 32'(r.sum));
          check($sformatf("g%0d acc_ovf_o", g), 32'(acc_ovf), 32'(r.ovf));
          check($sformatf("g%0d acc_cnt_o", g), 32'(acc_cnt), 32'(r.cnt));
        end
      end
    end

    initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check($sformatf("g%0d reset acc_o", g), 32'(acc), 32'd0);
      check($sformatf("g%0d reset acc_ovf_o", g), 32'(acc_ovf), 32'd0);
      check($sformatf("g%0d reset acc_cnt_o", g), 32'(acc_cnt), 32'd0);
      check($sformatf("g%0d reset acc_valid_o", g), 32'(acc_valid), 32'd0);
      check($sformatf("g%0d reset prod_ready_o", g), 32'(prod_ready), 32'd1);

      if (g == 0) begin
        // Full group, then an early-closed group.
        step(1, 8'hE1, 0, 0, 1, 0); step(1, 8'h10, 0, 0, 1, 0);
        step(1, 8'h01, 0, 0, 1, 0); step(1, 8'h04, 0, 0, 1, 0);
        step(1, 8'h05, 0, 0, 1, 0); step(1, 8'h07, 1, 0, 1, 0);
        // Back-pressured result, then consume with a simultaneous product.
        for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'h33, 0, 0, 0, 0);
        step(1, 8'h09, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 8'h01, 0, 0, 1, 0);
        // Clear mid-group, then a fresh group of 0x02.
        step(1, 8'h11, 0, 0, 1, 0); step(1, 8'h22, 0, 0, 1, 0);
        step(1, 8'h44, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 8'h02, 0, 0, 1, 0);
        // Reset mid-group, then a fresh group.
        step(1, 8'h11, 0, 0, 1, 0); step(1, 8'h22, 0, 0, 1, 0);
        step(1, 8'h44, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 8'h03, 0, 0, 1, 0);
      end else if (g == 1) begin
        for (int i = 0; i < 4; i++) step(1, 8'hE1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 8'h01, 0, 0, 1, 0);
      end else begin
        step(1, 8'h03, 0, 0, 1, 0); step(1, 8'h08, 0, 0, 1, 0);
        step(1, 8'h0F, 0, 0, 0, 0); step(1, 8'h05, 0, 0, 1, 0);
      end

      for (int i = 0; i < 400; i++)
        step(($urandom % 4) != 0, 8'($urandom_range(0, 255)),
             ($urandom % 5) == 0, ($urandom % 20) == 0,
             ($urandom % 3) != 0, (g == 0) && (($urandom % 60) == 0));

      for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1, 0);
      @(posedge clk);
      check($sformatf("g%0d scoreboard drained", g), 32'(exp_q.size()), 32'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    int cycles;
    cycles = 0;
    while (!(done[0] && done[1] && done[2]) && cycles < 20000) begin
      @(posedge clk);
      cycles++;
    end
    check("completion before timeout",
          32'(done[0] && done[1] && done[2]), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
